oam_dma_arbiter: RTL and testbench
==================================

# oam_dma_arbiter

Owns the single memory port between `sm83_core` and the memory map, and runs the OAM DMA engine. A core write to the DMA register (FF46) copies `DMA_LEN` bytes from `{FF46, 8'h00}` to OAM. While the copy runs, the core may touch only HRAM; the block arbitrates the read and write ports cycle by cycle. It sits between the core's bus outputs (`r_addr`, `w_addr`, `w_data`, `w_wen`, `r_data`) and the asynchronous-read memory system.

## Interface
- `DMA_REG_ADDR`, 16'hFF46, address of the DMA source register.
- `OAM_BASE`, 16'hFE00, first destination address.
- `DMA_LEN`, 160, bytes per transfer (1..256).
- `HRAM_LO` / `HRAM_HI`, 16'hFF80 / 16'hFFFE, inclusive core-accessible window during DMA.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `core_r_addr`  in  16  core read address.
- `core_w_addr`  in  16  core write address.
- `core_w_data`  in  8  core write data.
- `core_w_wen`  in  1  core write enable.
- `core_r_data`  out  8  read data returned to the core (combinational).
- `mem_r_addr`  out  16  memory read address.
- `mem_r_data`  in  8  memory read data, valid in the same cycle.
- `mem_w_addr`  out  16  memory write address.
- `mem_w_data`  out  8  memory write data.
- `mem_w_wen`  out  1  memory write enable.
- `dma_busy`  out  1  registered; high from the START state until the transfer returns to IDLE.

## Operation
- **Register:** `dma_src` is 8 bits, reset value 8'hFF.
  - A core write to `DMA_REG_ADDR` loads `dma_src` and enters START.
  - That write is never forwarded to memory.
  - Core reads of `DMA_REG_ADDR` return `dma_src` in any state.
- **States:**
  - IDLE → START on a register write.
  - START (one cycle) → XFER.
  - XFER → DRAIN after read index `DMA_LEN-1` is issued.
  - DRAIN → IDLE once the final buffered byte is written.
- **Index:** `idx` has width `$clog2(DMA_LEN)+1`.
  - Source address = `{dma_src,8'h00} + idx`, 16-bit, no echo remap.
  - Destination address = `OAM_BASE + idx`.
- **Pipeline:** a one-entry buffer holds `{valid, dest idx, data}`.
  - A DMA read captures `mem_r_data` into the buffer at the clock edge.
  - The buffered byte is written the next cycle the write port is free.
- **IDLE:** pure pass-through; `mem_*` mirror `core_*`, and `core_r_data = mem_r_data`.
- **Core access while `dma_busy`:**
  - Core reads outside HRAM, excluding `DMA_REG_ADDR`, return 8'hFF and do not reach memory.
  - Core writes outside HRAM are dropped.
- **Read-port arbitration:** a core HRAM read has priority; the DMA read is skipped that cycle and `idx` holds.
- **Write-port arbitration:**
  - A core HRAM write has priority; the buffered DMA byte is held.
  - If the buffer is valid and the write port is denied, no new DMA read is issued that cycle (buffer full).
- **Restart:** a register write while busy reloads `dma_src`, clears the buffer without writing it, sets `idx=0` and goes to START.
  - A restart in the same cycle as the DRAIN→IDLE transition also wins.
- **Reset mid-transfer:** all state is cleared immediately and the partial OAM contents are left as written.

## Timing
- **Reset values:**
  - `dma_busy=0`, state=IDLE, `idx=0`, buffer invalid, `dma_src=8'hFF`.
  - `mem_w_wen` follows `core_w_wen` (pass-through), so it is 0 whenever the core is not writing.
- **Nominal transfer (register write in cycle T, no stalls):**
  - T+1: START, `dma_busy=1`, no DMA memory access.
  - T+2 .. T+1+`DMA_LEN`: read index `i` in cycle T+2+i.
  - Byte `i` is written in cycle T+3+i, overlapping read `i+1`.
  - T+2+`DMA_LEN`: DRAIN, final write.
  - T+3+`DMA_LEN`: IDLE, `dma_busy=0`.
  - Total busy time is `DMA_LEN+2` cycles; 162 cycles by default.
- **Stalls:** each core HRAM read or write during XFER/DRAIN extends completion by at most one cycle.
- **Combinational paths:** `mem_*` and `core_r_data` are combinational from state, buffer and `core_*`. There is no added latency on core accesses.

## Test plan
- Reset, then core read 16'hFF46 → 8'hFF; IDLE pass-through write C000=5A then read → `mem_w_addr=C000`, `mem_w_wen=1`, read returns 5A.
- Preload C100..C19F with `i^8'h3C`; write FF46=C1 at T → `dma_busy` high T+1..T+162; FE00..FE9F equal `i^8'h3C`; reading FF46 returns C1.
- During DMA, core reads C000 → 8'hFF; core writes 8000=11 → no `mem_w_wen` to 8000; core reads/writes FF90 → serviced same cycle.
- Core writes HRAM every cycle for 10 cycles mid-XFER → no data loss, no duplicated OAM writes, `dma_busy` falls at T+172.
- Write FF46=C1, then FF46=D0 at T+50 → OAM ends with D000..D09F contents; `dma_busy` falls 162 cycles after the second write.
- Assert `rst` at T+80 → `dma_busy=0` and `mem_w_wen` reflects only core in the same cycle; FF46 reads 8'hFF.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter
//   Owns the single memory port between the CPU core and the memory map and
//   runs the OAM DMA engine. A core write to DMA_REG_ADDR latches a source page
//   and copies DMA_LEN bytes from {page, 8'h00} into OAM. While the copy runs,
//   the core may only reach HRAM; the read and write ports are arbitrated cycle
//   by cycle, with the core always winning a port it legitimately needs.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   core_r_addr         core read address
//   core_w_addr/_data   core write address / data
//   core_w_wen          core write enable
//   core_r_data         read data returned to the core (combinational)
//   mem_r_addr          memory read address
//   mem_r_data          memory read data (asynchronous, same cycle)
//   mem_w_addr/_data    memory write address / data
//   mem_w_wen           memory write enable
//   dma_busy            registered, high while a transfer is in progress
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          DMA_LEN      = 160,
  parameter logic [15:0] HRAM_LO      = 16'hFF80,
  parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] core_r_addr,
  input  logic [15:0] core_w_addr,
  input  logic [7:0]  core_w_data,
  input  logic        core_w_wen,
  output logic [7:0]  core_r_data,
  output logic [15:0] mem_r_addr,
  input  logic [7:0]  mem_r_data,
  output logic [15:0] mem_w_addr,
  output logic [7:0]  mem_w_data,
  output logic        mem_w_wen,
  output logic        dma_busy
);

  localparam int IDX_W = $clog2(DMA_LEN) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             buf_vld_q, buf_vld_d;
  logic [IDX_W-1:0] buf_idx_q, buf_idx_d;
  logic [7:0]       buf_data_q, buf_data_d;
  logic [7:0]       dma_src_q, dma_src_d;
  logic             dma_busy_q, dma_busy_d;

  logic        busy;
  logic        reg_wr;
  logic        reg_rd;
  logic        r_hram;
  logic        w_hram;
  logic        buf_wr;
  logic        dma_rd;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;

  assign dma_busy = dma_busy_q;

  always_comb begin
    busy   = (state_q != S_IDLE);
    reg_wr = core_w_wen && (core_w_addr == DMA_REG_ADDR);
    reg_rd = (core_r_addr == DMA_REG_ADDR);
    r_hram = (core_r_addr >= HRAM_LO) && (core_r_addr <= HRAM_HI);
    w_hram = core_w_wen && (core_w_addr >= HRAM_LO) && (core_w_addr <= HRAM_HI);
    // The buffered byte goes out whenever the core is not using the write
    // port; a restart discards it instead of writing it.
    buf_wr = busy && buf_vld_q && !w_hram && !reg_wr;
    // A DMA read needs the read port and somewhere to put the byte: either an
    // empty buffer or one that is draining this same cycle.
    dma_rd = (state_q == S_XFER) && !r_hram && !reg_wr && !(buf_vld_q && !buf_wr);
    src_addr = {dma_src_q, 8'h00} + 16'(idx_q);
    dst_addr = OAM_BASE + 16'(buf_idx_q);
  end

  // Port muxing: pass-through in IDLE, HRAM-only for the core while busy.
  always_comb begin
    mem_r_addr  = core_r_addr;
    mem_w_addr  = core_w_addr;
    mem_w_data  = core_w_data;
    mem_w_wen   = core_w_wen && !reg_wr;
    core_r_data = reg_rd ? dma_src_q : mem_r_data;
    if (busy) begin
      if (!r_hram) begin
        mem_r_addr  = src_addr;
        core_r_data = reg_rd ? dma_src_q : 8'hFF;
      end
      if (!w_hram) begin
        if (buf_wr) begin
          mem_w_addr = dst_addr;
          mem_w_data = buf_data_q;
          mem_w_wen  = 1'b1;
        end else begin
          mem_w_wen  = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_vld_d  = buf_vld_q;
    buf_idx_d  = buf_idx_q;
    buf_data_d = buf_data_q;
    dma_src_d  = dma_src_q;

    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_START: state_d = S_XFER;
      S_XFER:  if (dma_rd && (idx_q == LAST_IDX)) state_d = S_DRAIN;
      S_DRAIN: if (!buf_vld_q || buf_wr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (buf_wr) buf_vld_d = 1'b0;
    // A read in the same cycle as a drain refills the buffer behind it.
    if (dma_rd) begin
      buf_vld_d  = 1'b1;
      buf_idx_d  = idx_q;
      buf_data_d = mem_r_data;
      idx_d      = idx_q + IDX_W'(1);
    end

    // A register write (re)starts from any state, including the cycle that
    // would otherwise leave DRAIN.
    if (reg_wr) begin
      dma_src_d = core_w_data;
      state_d   = S_START;
      idx_d     = '0;
      buf_vld_d = 1'b0;
    end

    dma_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      buf_vld_q  <= 1'b0;
      buf_idx_q  <= '0;
      buf_data_q <= 8'h00;
      dma_src_q  <= 8'hFF;
      dma_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_vld_q  <= buf_vld_d;
      buf_idx_q  <= buf_idx_d;
      buf_data_q <= buf_data_d;
      dma_src_q  <= dma_src_d;
      dma_busy_q <= dma_busy_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
module tb_oam_dma_arbiter;

  localparam int LEN   = 160;
  localparam int BOUND = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] core_r_addr;
  logic [15:0] core_w_addr;
  logic [7:0]  core_w_data;
  logic        core_w_wen;
  logic [7:0]  core_r_data;
  logic [15:0] mem_r_addr;
  logic [7:0]  mem_r_data;
  logic [15:0] mem_w_addr;
  logic [7:0]  mem_w_data;
  logic        mem_w_wen;
  logic        dma_busy;

  logic [7:0] mem [0:65535];
  logic [7:0] exp_oam [0:LEN-1];
  int         oam_cnt [0:LEN-1];
  int         bad_wr;
  int         compared = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  assign mem_r_data = mem[mem_r_addr];

  oam_dma_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .core_r_addr (core_r_addr),
    .core_w_addr (core_w_addr),
    .core_w_data (core_w_data),
    .core_w_wen  (core_w_wen),
    .core_r_data (core_r_data),
    .mem_r_addr  (mem_r_addr),
    .mem_r_data  (mem_r_data),
    .mem_w_addr  (mem_w_addr),
    .mem_w_data  (mem_w_data),
    .mem_w_wen   (mem_w_wen),
    .dma_busy    (dma_busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_hram(input logic [15:0] a);
    return (a >= 16'hFF80) && (a <= 16'hFFFE);
  endfunction

  function automatic bit is_oam(input logic [15:0] a);
    return (a >= 16'hFE00) && (a < 16'(16'hFE00 + LEN));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    core_r_addr = 16'h0000;
    core_w_addr = 16'h0000;
    core_w_data = 8'h00;
    core_w_wen  = 1'b0;
  endtask

  // Advance one clock; the memory model commits whatever write was presented
  // during the cycle that just ended.
  task automatic step();
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    logic        b;
    w = mem_w_wen;
    a = mem_w_addr;
    d = mem_w_data;
    b = dma_busy;
    @(posedge clk);
    #1;
    if (w === 1'b1) begin
      mem[a] = d;
      if (is_oam(a)) oam_cnt[int'(a - 16'hFE00)]++;
      if (b === 1'b1 && !is_hram(a) && !is_oam(a)) bad_wr++;
    end
  endtask

  task automatic fill(input logic [7:0] page, input int pat);
    for (int i = 0; i < LEN; i++) begin
      logic [7:0] v;
      case (pat)
        0:       v = 8'(i) ^ 8'h3C;
        1:       v = 8'(i * 7 + 3);
        default: v = 8'($urandom_range(0, 255));
      endcase
      mem[{page, 8'h00} + 16'(i)] = v;
    end
  endtask

  task automatic prep(input logic [7:0] page);
    for (int i = 0; i < LEN; i++) begin
      mem[16'hFE00 + 16'(i)] = 8'h00;
      oam_cnt[i] = 0;
      exp_oam[i] = mem[{page, 8'h00} + 16'(i)];
    end
    bad_wr = 0;
  endtask

  task automatic check_oam(input string tag, input bit check_cnt);
    for (int i = 0; i < LEN; i++) begin
      check(tag, 32'(mem[16'hFE00 + 16'(i)]), 32'(exp_oam[i]));
      if (check_cnt) check({tag, "_wrcount"}, 32'(oam_cnt[i]), 32'd1);
    end
    check({tag, "_stray_writes"}, 32'(bad_wr), 32'd0);
  endtask

  // Register write in cycle T; returns in cycle T+1.
  task automatic start(input logic [7:0] src);
    core_r_addr = 16'h0000;
    core_w_addr = 16'hFF46;
    core_w_data = src;
    core_w_wen  = 1'b1;
    #1;
    check("regwr_not_forwarded", 32'(mem_w_wen), 32'd0);
    step();
    drive_idle();
    check("busy_at_T+1", 32'(dma_busy), 32'd1);
  endtask

  // Runs the core side while dma_busy is high; n counts busy cycles.
  // mode 0: idle core, 1: 10 HRAM writes mid-transfer, 2: random + directed,
  // 3: restart with page D0 at T+50.
  task automatic run_xfer(input int mode, input logic [7:0] src, output int n, output int stalls);
    logic [7:0] cur;
    cur    = src;
    n      = 0;
    stalls = 0;
    while (dma_busy === 1'b1 && n < BOUND) begin
      int          rk;
      int          wk;
      logic [15:0] ra;
      logic [15:0] wa;
      logic [7:0]  wd;
      rk = 0; wk = 0; ra = 16'h0000; wa = 16'h0000; wd = 8'h00;
      case (mode)
        1: if (n >= 30 && n < 40) begin wk = 1; wa = 16'hFF80 + 16'(n); wd = 8'(n); end
        2: begin
          if (n == 5) begin rk = 2; ra = 16'hC000; end
          else if (n == 6) begin wk = 2; wa = 16'h8000; wd = 8'h11; end
          else if (n == 7) begin rk = 1; ra = 16'hFF90; end
          else if (n == 8) begin wk = 1; wa = 16'hFF90; wd = 8'h77; end
          else if (n > 8) begin
            rk = int'($urandom_range(0, 3));
            wk = int'($urandom_range(0, 2));
            case (rk)
              1:       ra = 16'hFF80 + 16'($urandom_range(0, 126));
              2:       ra = 16'($urandom_range(0, 16'h7FFF));
              3:       ra = 16'hFF46;
              default: ra = 16'h0000;
            endcase
            if (wk == 1) wa = 16'hFF80 + 16'($urandom_range(0, 126));
            if (wk == 2) wa = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
            wd = 8'($urandom_range(0, 255));
          end
        end
        3: if (n == 49) begin wk = 3; wa = 16'hFF46; wd = 8'hD0; end
        default: ;
      endcase
      core_r_addr = ra;
      core_w_addr = wa;
      core_w_data = wd;
      core_w_wen  = (wk != 0);
      #1;
      if (mode == 0 && n == 0) check("start_no_write", 32'(mem_w_wen), 32'd0);
      if (mode == 0 && n == 1) begin
        check("first_read_addr", 32'(mem_r_addr), 32'({src, 8'h00}));
        check("first_read_no_write", 32'(mem_w_wen), 32'd0);
      end
      if (mode == 0 && n == 2) begin
        check("first_write_wen", 32'(mem_w_wen), 32'd1);
        check("first_write_addr", 32'(mem_w_addr), 32'hFE00);
      end
      if (rk == 1) begin
        stalls++;
        check("hram_rd_addr", 32'(mem_r_addr), 32'(ra));
        check("hram_rd_data", 32'(core_r_data), 32'(mem[ra]));
      end
      if (rk == 2) check("blocked_rd_ff", 32'(core_r_data), 32'hFF);
      if (rk == 3) check("reg_rd_busy", 32'(core_r_data), 32'(cur));
      if (wk == 1) begin
        stalls++;
        check("hram_wr_wen", 32'(mem_w_wen), 32'd1);
        check("hram_wr_addr", 32'(mem_w_addr), 32'(wa));
        check("hram_wr_data", 32'(mem_w_data), 32'(wd));
      end
      if (wk == 2) check("blocked_wr_dropped", 32'(mem_w_wen && (mem_w_addr == wa)), 32'd0);
      if (wk == 3) begin
        check("restart_no_write", 32'(mem_w_wen), 32'd0);
        cur = wd;
      end
      n++;
      step();
    end
    drive_idle();
  endtask

  initial begin
    int n;
    int stalls;
    logic [7:0] page;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    bad_wr = 0;
    rst = 1'b1;
    drive_idle();
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state and IDLE pass-through
    check("reset_busy", 32'(dma_busy), 32'd0);
    core_r_addr = 16'hFF46;
    #1;
    check("reset_reg_rd", 32'(core_r_data), 32'hFF);
    check("reset_wen", 32'(mem_w_wen), 32'd0);
    core_w_addr = 16'hC000;
    core_w_data = 8'h5A;
    core_w_wen  = 1'b1;
    #1;
    check("idle_wr_addr", 32'(mem_w_addr), 32'hC000);
    check("idle_wr_wen", 32'(mem_w_wen), 32'd1);
    check("idle_wr_data", 32'(mem_w_data), 32'h5A);
    step();
    drive_idle();
    core_r_addr = 16'hC000;
    #1;
    check("idle_rd_addr", 32'(mem_r_addr), 32'hC000);
    check("idle_rd_data", 32'(core_r_data), 32'h5A);
    drive_idle();

    // Nominal transfer from C100
    fill(8'hC1, 0);
    prep(8'hC1);
    start(8'hC1);
    run_xfer(0, 8'hC1, n, stalls);
    check("nominal_busy_cycles", 32'(n), 32'd162);
    check_oam("nominal_oam", 1'b1);
    core_r_addr = 16'hFF46;
    #1;
    check("reg_rd_after", 32'(core_r_data), 32'hC1);
    drive_idle();

    // Ten back-to-back HRAM writes mid-transfer
    prep(8'hC1);
    start(8'hC1);
    run_xfer(1, 8'hC1, n, stalls);
    check("stall_busy_cycles", 32'(n), 32'd172);
    check_oam("stall_oam", 1'b1);

    // Random core traffic during a transfer from a random page
    page = 8'hC2 + 8'($urandom_range(0, 29));
    fill(page, 2);
    prep(page);
    start(page);
    run_xfer(2, page, n, stalls);
    check("rand_busy_min", 32'(n >= 162), 32'd1);
    check("rand_busy_max", 32'(n <= 162 + stalls), 32'd1);
    check_oam("rand_oam", 1'b1);

    // Restart at T+50 with page D0
    fill(8'hC1, 0);
    fill(8'hD0, 1);
    prep(8'hD0);
    start(8'hC1);
    run_xfer(3, 8'hC1, n, stalls);
    check("restart_busy_cycles", 32'(n), 32'd212);
    check_oam("restart_oam", 1'b0);
    core_r_addr = 16'hFF46;
    #1;
    check("restart_reg_rd", 32'(core_r_data), 32'hD0);
    drive_idle();

    // Asynchronous reset at T+80
    prep(8'hC1);
    start(8'hC1);
    for (int k = 0; k < 79; k++) step();
    check("pre_reset_busy", 32'(dma_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(dma_busy), 32'd0);
    check("rst_wen_idle", 32'(mem_w_wen), 32'd0);
    core_w_addr = 16'h8000;
    core_w_data = 8'h22;
    core_w_wen  = 1'b1;
    core_r_addr = 16'hFF46;
    #1;
    check("rst_wen_core", 32'(mem_w_wen), 32'd1);
    check("rst_waddr_core", 32'(mem_w_addr), 32'h8000);
    check("rst_reg_rd", 32'(core_r_data), 32'hFF);
    drive_idle();
    step();
    rst = 1'b0;
    step();
    step();
    check("post_rst_busy", 32'(dma_busy), 32'd0);
    check("partial_oam_0", 32'(mem[16'hFE00]), 32'h3C);
    check("partial_oam_70", 32'(mem[16'hFE46]), 32'(8'd70 ^ 8'h3C));
    check("partial_oam_100", 32'(mem[16'hFE64]), 32'h00);
    check("partial_oam_159", 32'(mem[16'hFE9F]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
